rx_demux: RTL and testbench

RX_DEMUX -- requirements
Module: rx_demux

---
 rtl/rx_demux_pkg.sv | 15 +
 rtl/rx_lock_fsm.sv | 82 ++++++++
 rtl/rx_demux.sv | 51 +++++
 tb/tb_rx_demux.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_demux_pkg.sv
// Shared definitions for the symbol receive demux: lock FSM encoding and
// the default alignment / skip symbol values.
package rx_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_ALIGNED = 2'd2
    } rx_state_e;

    localparam logic [7:0] COM_SYM   = 8'hBC;
    localparam logic [7:0] SKP_SYM   = 8'h1C;
    localparam int         GAP_LIMIT = 4;

endpackage

// File: rtl/rx_lock_fsm.sv
// Comma detection and lock tracking: counts consecutive valid COM symbols to
// acquire alignment and drops lock after GAP_LIMIT idle cycles.
module rx_lock_fsm
    import rx_demux_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_SYM),
    parameter int               LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sym,
    input  logic             sym_valid,
    output rx_state_e        state,
    output logic             locked
);

    localparam int             CW       = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0]  LOCK_MAX = CW'(LOCK_COUNT);
    localparam logic [2:0]     GAP_MAX  = 3'(GAP_LIMIT);

    rx_state_e     state_next;
    logic [CW-1:0] com_cnt, com_cnt_next;
    logic [2:0]    gap_cnt, gap_cnt_next;
    logic          is_com;

    assign is_com = (sym == COM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            com_cnt <= '0;
            gap_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            state   <= state_next;
            com_cnt <= com_cnt_next;
            gap_cnt <= gap_cnt_next;
            locked  <= (state_next == ST_ALIGNED);
        end
    end

    always_comb begin
        state_next   = state;
        com_cnt_next = com_cnt;
        gap_cnt_next = gap_cnt;
        // The gap count only has meaning while aligned; start each lock fresh.
        if (state != ST_ALIGNED) gap_cnt_next = '0;
        if (sym_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_com) begin
                        com_cnt_next = CW'(1);
                        state_next   = (LOCK_COUNT <= 1) ? ST_ALIGNED : ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!is_com) begin
                        com_cnt_next = '0;
                        state_next   = ST_IDLE;
                    end else if (com_cnt >= LOCK_MAX - 1'b1) begin
                        com_cnt_next = LOCK_MAX;
                        state_next   = ST_ALIGNED;
                    end else begin
                        com_cnt_next = com_cnt + 1'b1;
                    end
                end
                ST_ALIGNED: gap_cnt_next = '0;
                default:    state_next   = ST_IDLE;
            endcase
        end else if (state == ST_ALIGNED) begin
            if (gap_cnt >= GAP_MAX - 1'b1) begin
                gap_cnt_next = GAP_MAX;
                com_cnt_next = '0;
                state_next   = ST_IDLE;
            end else begin
                gap_cnt_next = gap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_demux.sv
// Receive demux: strips COM/SKP framing from an aligned symbol stream and
// forwards payload symbols with one cycle of registered latency.
module rx_demux
    import rx_demux_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_SYM),
    parameter logic [WIDTH-1:0] SKP        = WIDTH'(SKP_SYM),
    parameter int               LOCK_COUNT = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] Rx_buffer,
    input  logic             VALID,
    output logic             VALID_OUT,
    output logic [WIDTH-1:0] DATA,
    output logic             LOCKED
);

    // VALID qualifies Rx_buffer for the current cycle only; there is no
    // backpressure. VALID_OUT qualifies DATA exactly one cycle after sampling.
    rx_state_e lock_state;
    logic      fwd;

    rx_lock_fsm #(
        .WIDTH      (WIDTH),
        .COM        (COM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock_fsm (
        .clk       (CLK),
        .rst       (RESET),
        .sym       (Rx_buffer),
        .sym_valid (VALID),
        .state     (lock_state),
        .locked    (LOCKED)
    );

    assign fwd = VALID && (lock_state == ST_ALIGNED) &&
                 (Rx_buffer != COM) && (Rx_buffer != SKP);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            VALID_OUT <= 1'b0;
            DATA      <= '0;
        end else begin
            VALID_OUT <= fwd;
            if (fwd) DATA <= Rx_buffer;
        end
    end

endmodule

// File: tb/tb_rx_demux.sv
// Self-checking bench for rx_demux: directed scenarios plus a randomized
// stream, all compared against a behavioural lock/forward model.
module tb_rx_demux;

    localparam logic [7:0] C = 8'hBC;
    localparam logic [7:0] S = 8'h1C;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] rx;
    logic       vo;
    logic [7:0] data;
    logic       locked;

    int checks = 0;
    int errors = 0;

    // Reference model: lock is acquired after two back-to-back valid COMs,
    // lost after four idle cycles; payload is anything but COM/SKP.
    int         m_run, m_gap;
    bit         m_lock, m_vo;
    logic [7:0] m_data;
    logic [7:0] exp_q[$];

    rx_demux #(.WIDTH(8), .COM(8'hBC), .SKP(8'h1C), .LOCK_COUNT(2)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .Rx_buffer (rx),
        .VALID     (valid),
        .VALID_OUT (vo),
        .DATA      (data),
        .LOCKED    (locked)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_gap = 0; m_lock = 0; m_vo = 0; m_data = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] s);
        m_vo = 0;
        if (!v) begin
            if (m_lock) begin
                m_gap++;
                if (m_gap >= 4) begin m_lock = 0; m_run = 0; m_gap = 0; end
            end
        end else begin
            m_gap = 0;
            if (m_lock) begin
                if (s != C && s != S) begin
                    m_vo = 1; m_data = s; exp_q.push_back(s);
                end
            end else if (s == C) begin
                m_run++;
                if (m_run >= 2) m_lock = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    // Drive one symbol slot and advance the model to the post-edge outputs.
    task automatic cycle(input bit v, input logic [7:0] s);
        @(negedge clk);
        valid = v; rx = s;
        @(posedge clk);
        #1;
        model_step(v, s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; rx = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = 1'b0; rx = 8'h00;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vo, data, locked} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: vo=%b data=%h locked=%b expected 0/00/0", vo, data, locked);
        end
        model_reset();
        @(negedge clk); rst = 1'b0;
        cycle(1'b0, 8'h00);
        checks++;
        if ({vo, data, locked} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: vo=%b data=%h locked=%b expected 0/00/0", vo, data, locked);
        end
    endtask

    task automatic test_lock_forward();
        logic [7:0] seq [4] = '{8'hBC, 8'hBC, 8'h5A, 8'h3C};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, seq[i]);
            checks++;
            if ({vo, data, locked} !== {m_vo, m_data, m_lock}) begin
                errors++;
                $display("FAIL lock_fwd[%0d]: vo=%b data=%h locked=%b expected %b/%h/%b",
                         i, vo, data, locked, m_vo, m_data, m_lock);
            end
        end
        checks++;
        if ({vo, data, locked} !== {1'b1, 8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL lock_fwd_last: vo=%b data=%h locked=%b expected 1/3c/1", vo, data, locked);
        end
    endtask

    task automatic test_false_sync();
        logic [7:0] seq [4] = '{8'hBC, 8'h77, 8'hBC, 8'hBC};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, seq[i]);
            checks++;
            if ({vo, data, locked} !== {m_vo, m_data, m_lock} || locked !== (i == 3)) begin
                errors++;
                $display("FAIL false_sync[%0d]: vo=%b data=%h locked=%b expected %b/%h/%b",
                         i, vo, data, locked, m_vo, m_data, m_lock);
            end
        end
    endtask

    task automatic test_consumed();
        logic [7:0] seq [5] = '{8'hBC, 8'hBC, 8'h1C, 8'hBC, 8'hA5};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, seq[i]);
            checks++;
            if ({vo, data, locked} !== {m_vo, m_data, m_lock} || vo !== (i == 4)) begin
                errors++;
                $display("FAIL consumed[%0d]: vo=%b data=%h locked=%b expected %b/%h/%b",
                         i, vo, data, locked, m_vo, m_data, m_lock);
            end
        end
    endtask

    task automatic test_loss_of_lock();
        // 3 idle cycles keep lock, 4 idle cycles drop it.
        bit         v_seq [13] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1};
        logic [7:0] s_seq [13] = '{8'hBC, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h77,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h5A};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(v_seq[i], s_seq[i]);
            checks++;
            if ({vo, data, locked} !== {m_vo, m_data, m_lock}) begin
                errors++;
                $display("FAIL loss_lock[%0d]: vo=%b data=%h locked=%b expected %b/%h/%b",
                         i, vo, data, locked, m_vo, m_data, m_lock);
            end
        end
        checks++;
        if ({vo, data, locked} !== {1'b0, 8'h77, 1'b0}) begin
            errors++;
            $display("FAIL loss_lock_final: vo=%b data=%h locked=%b expected 0/77/0", vo, data, locked);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] pre  [4] = '{8'hBC, 8'hBC, 8'h11, 8'h22};
        logic [7:0] post [3] = '{8'hBC, 8'hBC, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, pre[i]);
            checks++;
            if ({vo, data, locked} !== {m_vo, m_data, m_lock}) begin
                errors++;
                $display("FAIL mid_rst_pre[%0d]: vo=%b data=%h locked=%b expected %b/%h/%b",
                         i, vo, data, locked, m_vo, m_data, m_lock);
            end
        end
        #2 rst = 1'b1;
        valid = 1'b1; rx = 8'h33;
        #1;
        checks++;
        if ({vo, data, locked} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_rst_async: vo=%b data=%h locked=%b expected 0/00/0", vo, data, locked);
        end
        #3 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        model_step(1'b1, 8'h33);
        checks++;
        if ({vo, data, locked} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_rst_release: vo=%b data=%h locked=%b expected 0/00/0", vo, data, locked);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, post[i]);
            checks++;
            if ({vo, data, locked} !== {m_vo, m_data, m_lock}) begin
                errors++;
                $display("FAIL mid_rst_relock[%0d]: vo=%b data=%h locked=%b expected %b/%h/%b",
                         i, vo, data, locked, m_vo, m_data, m_lock);
            end
        end
        checks++;
        if ({vo, data, locked} !== {1'b1, 8'h44, 1'b1}) begin
            errors++;
            $display("FAIL mid_rst_final: vo=%b data=%h locked=%b expected 1/44/1", vo, data, locked);
        end
    endtask

    task automatic test_random();
        bit         v;
        logic [7:0] s;
        logic [7:0] e;
        int         sel;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            if (sel < 4)       s = C;
            else if (sel == 4) s = S;
            else               s = 8'($urandom_range(0, 255));
            cycle(v, s);
            checks++;
            if ({vo, data, locked} !== {m_vo, m_data, m_lock}) begin
                errors++;
                $display("FAIL random[%0d]: vo=%b data=%h locked=%b expected %b/%h/%b",
                         i, vo, data, locked, m_vo, m_data, m_lock);
            end
            if (vo === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_sb[%0d]: unexpected output %h, expected none", i, data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL random_sb[%0d]: data=%h expected %h", i, data, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: %0d forwarded symbols missing, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_lock_forward();
        test_false_sync();
        test_consumed();
        test_loss_of_lock();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
